// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding UART_tx one frame at a time over a TxEn/TxData/TxDone handshake.
// Define UART_TX_FIFO_OVF_EN to get a sticky overflow flag on ovf_o; otherwise ovf_o is tied low.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  wr_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  TxDone,
  output logic                  TxEn,
  output logic [WIDTH-1:0]      TxData,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  busy_o,
  output logic                  ovf_o,
  input  logic                  ovf_clr_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam logic [DEPTH_LOG2:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] LVL_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [1:0]          state_q, state_d;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] level_q, level_d;
  logic                full_q, empty_q, busy_q, txen_q;
  logic [WIDTH-1:0]    txdata_q, txdata_d;
  logic                push_s, pop_s;

  // Full uses the registered flag, so a same-cycle pop never frees a slot for this write.
  assign push_s = wr_i & ~full_q;
  assign pop_s  = (state_q == ST_LOAD);

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) state_d = ST_LOAD;
        else          state_d = ST_IDLE;
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        if (TxDone) state_d = ST_GAP;
        else        state_d = ST_SEND;
      end
      ST_GAP: begin
        if (!empty_q) state_d = ST_LOAD;
        else          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
    else        wr_ptr_d = wr_ptr_q;

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      txdata_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end else begin
      rd_ptr_d = rd_ptr_q;
      txdata_d = txdata_q;
    end

    level_d = wr_ptr_d - rd_ptr_d;
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge Clk) begin
    if (push_s) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= data_i;
  end

  // Control, pointer and registered status state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= LVL_ZERO;
      rd_ptr_q <= LVL_ZERO;
      level_q  <= LVL_ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      busy_q   <= 1'b0;
      txen_q   <= 1'b0;
      txdata_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == LVL_FULL);
      empty_q  <= (level_d == LVL_ZERO);
      busy_q   <= (state_d != ST_IDLE);
      txen_q   <= (state_d == ST_SEND);
      txdata_q <= txdata_d;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic drop_s;
  logic ovf_q;

  assign drop_s = wr_i & full_q;

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ovf_q <= 1'b0;
    else        ovf_q <= drop_s | (ovf_q & ~ovf_clr_i);
  end

  assign ovf_o = ovf_q;
`else
  logic ovf_unused_s;

  assign ovf_unused_s = ovf_clr_i;
  assign ovf_o        = 1'b0;
`endif

  assign TxEn    = txen_q;
  assign TxData  = txdata_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: the bench plays the UART_tx role (TxDone pulses)
// and keeps a byte queue of what must appear on TxData, in order.
module tb_uart_tx_fifo;

  logic       Clk;
  logic       Rst_n;
  logic       wr_i;
  logic [7:0] data_i;
  logic       TxDone;
  logic       TxEn;
  logic [7:0] TxData;
  logic       full_o;
  logic       empty_o;
  logic [4:0] level_o;
  logic       busy_o;
  logic       ovf_o;
  logic       ovf_clr_i;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  logic       ovf_exp;

  uart_tx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .wr_i      (wr_i),
    .data_i    (data_i),
    .TxDone    (TxDone),
    .TxEn      (TxEn),
    .TxData    (TxData),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .level_o   (level_o),
    .busy_o    (busy_o),
    .ovf_o     (ovf_o),
    .ovf_clr_i (ovf_clr_i)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic burst(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      data_i = start + 8'(i);
      wr_i   = 1'b1;
      exp_q.push_back(data_i);
      tick();
    end
    wr_i = 1'b0;
  endtask

  task automatic done_pulse();
    TxDone = 1'b1;
    tick();
    TxDone = 1'b0;
  endtask

  task automatic wait_txen(input string tag);
    int n;
    n = 0;
    while (TxEn !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_txen"}, 32'(TxEn), 32'd1);
  endtask

  // Accept one frame: check its byte against the queue head, hold, then signal done.
  task automatic serve(input string tag);
    wait_txen(tag);
    chk({tag, "_data"}, 32'(TxData), 32'(exp_q.pop_front()));
    tick();
    tick();
    done_pulse();
  endtask

  initial begin
    int sizes [7];
    int base;
    int txen_seen;
    sizes = '{3, 7, 1, 12, 5, 9, 3};

`ifdef UART_TX_FIFO_OVF_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif

    Rst_n = 1'b0; wr_i = 1'b0; data_i = 8'h00; TxDone = 1'b0; ovf_clr_i = 1'b0;
    tick();
    tick();
    chk("rst_txen",  32'(TxEn),    32'd0);
    chk("rst_txdat", 32'(TxData),  32'd0);
    chk("rst_full",  32'(full_o),  32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_busy",  32'(busy_o),  32'd0);
    chk("rst_ovf",   32'(ovf_o),   32'd0);
    Rst_n = 1'b1;
    tick();

    // Single byte: latency N+1 status, N+2 LOAD, N+3 SEND.
    burst(8'hA5, 1);
    chk("s1_empty", 32'(empty_o), 32'd0);
    chk("s1_level", 32'(level_o), 32'd1);
    chk("s1_txen0", 32'(TxEn),    32'd0);
    tick();
    chk("s1_load_busy", 32'(busy_o), 32'd1);
    chk("s1_load_txen", 32'(TxEn),   32'd0);
    tick();
    chk("s1_txen",  32'(TxEn),    32'd1);
    chk("s1_data",  32'(TxData),  32'(exp_q.pop_front()));
    chk("s1_empty2", 32'(empty_o), 32'd1);
    tick();
    tick();
    done_pulse();
    chk("s1_gap_txen", 32'(TxEn),   32'd0);
    chk("s1_gap_busy", 32'(busy_o), 32'd1);
    tick();
    chk("s1_idle_busy", 32'(busy_o), 32'd0);
    done_pulse();
    chk("s1_stray_done_busy", 32'(busy_o), 32'd0);
    chk("s1_stray_done_txen", 32'(TxEn),   32'd0);

    // Burst 0x01..0x05 with back-to-back frames.
    burst(8'h01, 5);
    wait_txen("b2");
    for (int i = 0; i < 5; i++) begin
      chk("b2_data", 32'(TxData), 32'(exp_q.pop_front()));
      tick();
      tick();
      done_pulse();
      chk("b2_gap_txen", 32'(TxEn),   32'd0);
      chk("b2_gap_busy", 32'(busy_o), 32'd1);
      tick();
      if (i < 4) begin
        chk("b2_load_txen", 32'(TxEn), 32'd0);
        tick();
        chk("b2_send_txen", 32'(TxEn), 32'd1);
      end else begin
        chk("b2_idle_busy", 32'(busy_o), 32'd0);
      end
    end
    tick();

    // Fill with TxDone held low; 0x10 sits in TxData.
    burst(8'h10, 16);
    chk("f3_level15", 32'(level_o), 32'd15);
    chk("f3_full0",   32'(full_o),  32'd0);
    burst(8'h20, 1);
    chk("f3_level16", 32'(level_o), 32'd16);
    chk("f3_full1",   32'(full_o),  32'd1);
    data_i = 8'h21;
    wr_i   = 1'b1;
    tick();
    wr_i = 1'b0;
    chk("f3_level_drop", 32'(level_o), 32'd16);
    chk("f3_txdata",     32'(TxData),  32'h10);
    chk("f3_ovf_set",    32'(ovf_o),   32'(ovf_exp));
    data_i    = 8'h22;
    wr_i      = 1'b1;
    ovf_clr_i = 1'b1;
    tick();
    wr_i = 1'b0;
    chk("f3_ovf_set_wins", 32'(ovf_o),   32'(ovf_exp));
    chk("f3_level_drop2",  32'(level_o), 32'd16);
    tick();
    ovf_clr_i = 1'b0;
    chk("f3_ovf_clr", 32'(ovf_o), 32'd0);
    repeat (17) serve("f3_drain");
    tick();
    tick();
    chk("f3_level_end", 32'(level_o), 32'd0);
    chk("f3_empty_end", 32'(empty_o), 32'd1);
    chk("f3_busy_end",  32'(busy_o),  32'd0);

    // Wrap-around: 40 bytes in mixed bursts.
    base = 0;
    for (int k = 0; k < 7; k++) begin
      burst(8'(8'h40 + base), sizes[k]);
      base = base + sizes[k];
      repeat (sizes[k]) serve("w4");
    end
    tick();
    tick();
    chk("w4_level_end", 32'(level_o), 32'd0);
    chk("w4_busy_end",  32'(busy_o),  32'd0);

    // Push during the LOAD pop with three queued.
    burst(8'hC1, 4);
    chk("sp_pre_level", 32'(level_o), 32'd3);
    chk("sp_pre_data",  32'(TxData),  32'(exp_q.pop_front()));
    done_pulse();
    chk("sp_gap_level", 32'(level_o), 32'd3);
    tick();
    chk("sp_load_txen", 32'(TxEn), 32'd0);
    burst(8'hC5, 1);
    chk("sp_level", 32'(level_o), 32'd3);
    chk("sp_txen",  32'(TxEn),    32'd1);
    chk("sp_data",  32'(TxData),  32'(exp_q.pop_front()));

    // Asynchronous reset while sending with four queued.
    burst(8'hC6, 1);
    chk("rm_level4", 32'(level_o), 32'd4);
    chk("rm_send",   32'(TxEn),    32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("rm_txen",  32'(TxEn),    32'd0);
    chk("rm_empty", 32'(empty_o), 32'd1);
    chk("rm_level", 32'(level_o), 32'd0);
    chk("rm_busy",  32'(busy_o),  32'd0);
    exp_q.delete();
    tick();
    Rst_n = 1'b1;
    txen_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (TxEn === 1'b1) txen_seen++;
    end
    chk("rm_no_frames", 32'(txen_seen), 32'd0);
    chk("rm_busy_after", 32'(busy_o),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
